exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter VECTOR, default 32'hBFC0_0380: exception handler entry address.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2: flush hold cycles after redirect, legal range 1..15.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- commit_valid  in  1  memory-stage instruction valid this cycle.
- commit_pc  in  32  PC of that instruction.
- commit_bd  in  1  instruction sits in a branch delay slot.
- exc_if_adel, exc_ri, exc_ov, exc_syscall, exc_break, exc_adel, exc_ades, exc_eret  in  1 each  exception/ERET flags for that instruction.
- commit_dvaddr  in  32  data virtual address of that instruction.
- hw_int  in  6  external interrupt lines, asynchronous to clk.
- epc_address  in  32  current EPC from CP0.
- allow_interrupt  in  1  CP0 status permits interrupts.
- interrupt_flag  in  8  CP0 pending-and-enabled interrupt bits.
- hw_int_sync  out  6  synchronized hw_int, for CP0 Cause.IP[7:2].
- exp_en, exp_badvaddr_en, exp_bd, exl_clean  out  1 each  CP0 exception update strobes.
- exp_badvaddr, exp_epc  out  32  CP0 exception update values.
- exp_code  out  5  CP0 ExcCode.
- flush  out  1  kill all pipeline stages.
- redirect_valid  out  1  fetch-PC override strobe.
- redirect_pc  out  32  new fetch PC.

Function
REQ-004 SHALL pass hw_int through a two-flop synchronizer; hw_int_sync is the second flop.
REQ-005 SHALL have states IDLE, REDIRECT, DRAIN.
REQ-006 In IDLE with commit_valid=1, an event SHALL be accepted when any exc_* flag is 1, or when allow_interrupt=1 and interrupt_flag!=0.
REQ-007 SHALL select the event by fixed priority: interrupt (code 0), exc_if_adel (4), exc_ri (10), exc_ov (12), exc_syscall (8), exc_break (9), exc_adel (4), exc_ades (5), exc_eret.
REQ-008 On acceptance SHALL move to REDIRECT and register all exp_* and redirect outputs; every output SHALL be registered, giving exactly 1 cycle latency from the commit edge.
REQ-009 In REDIRECT, for a non-ERET event, SHALL drive for that one cycle: exp_en=1, exl_clean=0, exp_code=selected code, exp_bd=commit_bd, exp_epc=commit_bd ? commit_pc-4 : commit_pc (modulo 2^32), redirect_valid=1, redirect_pc=VECTOR, flush=1.
REQ-010 exp_badvaddr_en SHALL be 1 with exp_badvaddr=commit_pc for exc_if_adel, 1 with commit_dvaddr for exc_adel/exc_ades, and 0 otherwise; for interrupts it SHALL be 0.
REQ-011 In REDIRECT, for an ERET event, SHALL drive: exp_en=1, exl_clean=1, exp_epc=epc_address sampled at acceptance, exp_code and exp_bd = values of the last non-ERET event (0 after reset), exp_badvaddr_en=0, redirect_valid=1, redirect_pc=epc_address sampled at acceptance, flush=1.
REQ-012 REDIRECT SHALL always last one cycle, then enter DRAIN with a 4-bit counter loaded with DRAIN_CYCLES.
REQ-013 In DRAIN SHALL hold flush=1, with exp_en=0 and redirect_valid=0, while decrementing the counter each cycle; commits and interrupts SHALL be ignored.
REQ-014 When the counter reaches 0, SHALL return to IDLE, where flush=0 and new events may be accepted on the same cycle.
REQ-015 In IDLE with no accepted event, all strobes (exp_en, exp_badvaddr_en, redirect_valid, flush, exl_clean) SHALL be 0.
REQ-016 commit_valid=0 SHALL block acceptance even while an interrupt is pending; the interrupt SHALL be taken on the next valid commit.
REQ-017 Interrupt plus a synchronous exception on the same instruction SHALL take the interrupt, code 0, with EPC computed per REQ-009.
REQ-018 exc_eret together with any other exc_* flag SHALL take the other exception; exl_clean=0.

Reset
REQ-019 Asserting rst SHALL immediately force, including mid-REDIRECT or mid-DRAIN:
- state=IDLE, counter=0;
- synchronizer flops, last-code and last-bd registers = 0;
- every output = 0, redirect_pc and exp_* included.
REQ-020 The first event SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-021 Bench SHALL cover:
- commit_pc=32'h8000_0010, exc_ov=1, commit_bd=0 -> next cycle exp_en=1, exp_code=12, exp_epc=32'h8000_0010, redirect_pc=32'hBFC0_0380; flush=1 for 3 cycles total.
- commit_pc=32'h8000_0024, commit_bd=1, exc_adel=1, commit_dvaddr=32'h1234_5671 -> exp_code=4, exp_epc=32'h8000_0020, exp_bd=1, exp_badvaddr_en=1, exp_badvaddr=32'h1234_5671.
- After that event, exc_eret=1 with epc_address=32'h8000_0020 -> exl_clean=1, exp_code=4, exp_bd=1, redirect_pc=32'h8000_0020.
- allow_interrupt=1, interrupt_flag=8'h04, exc_syscall=1 on the same commit -> exp_code=0, exp_badvaddr_en=0.
- Second event committed during DRAIN -> no exp_en; rst asserted mid-DRAIN -> flush=0 at once, no redirect.
- hw_int[3] rises at cycle N -> hw_int_sync[3]=1 by the edge after cycle N+2.

Source files
------------

// File: rtl/exception_ctrl.sv
// Exception/ERET/interrupt controller: picks one event per commit, emits CP0
// update strobes and a fetch redirect, then holds flush while the pipe drains.
module exception_ctrl #(
   parameter logic [31:0] VECTOR       = 32'hBFC0_0380,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid,
   input  logic [31:0] commit_pc,
   input  logic        commit_bd,
   input  logic        exc_if_adel,
   input  logic        exc_ri,
   input  logic        exc_ov,
   input  logic        exc_syscall,
   input  logic        exc_break,
   input  logic        exc_adel,
   input  logic        exc_ades,
   input  logic        exc_eret,
   input  logic [31:0] commit_dvaddr,
   input  logic [5:0]  hw_int,
   input  logic [31:0] epc_address,
   input  logic        allow_interrupt,
   input  logic [7:0]  interrupt_flag,
   output logic [5:0]  hw_int_sync,
   output logic        exp_en,
   output logic        exp_badvaddr_en,
   output logic        exp_bd,
   output logic        exl_clean,
   output logic [31:0] exp_badvaddr,
   output logic [31:0] exp_epc,
   output logic [4:0]  exp_code,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      DRAIN    = 2'd2
   } state_t;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [4:0]  last_code, last_code_n;
   logic        last_bd, last_bd_n;
   logic [5:0]  sync1;

   logic        exp_en_n, exp_badvaddr_en_n, exp_bd_n, exl_clean_n;
   logic [31:0] exp_badvaddr_n, exp_epc_n, redirect_pc_n;
   logic [4:0]  exp_code_n;
   logic        flush_n, redirect_valid_n;

   logic        int_req, sync_exc, accept;
   logic [4:0]  code_sel;
   logic        bv_en_sel;
   logic [31:0] bv_sel, epc_calc;

   assign int_req  = allow_interrupt && (interrupt_flag != 8'd0);
   assign sync_exc = exc_if_adel | exc_ri | exc_ov | exc_syscall |
                     exc_break | exc_adel | exc_ades;
   assign accept   = commit_valid && (sync_exc || exc_eret || int_req);
   assign epc_calc = commit_bd ? (commit_pc - 32'd4) : commit_pc;
   assign dbg_state = state;

   // Fixed priority among non-ERET causes; interrupt wins over everything.
   always_comb begin
      code_sel  = 5'd0;
      bv_en_sel = 1'b0;
      bv_sel    = 32'd0;
      if (int_req) begin
         code_sel = 5'd0;
      end else if (exc_if_adel) begin
         code_sel  = 5'd4;
         bv_en_sel = 1'b1;
         bv_sel    = commit_pc;
      end else if (exc_ri) begin
         code_sel = 5'd10;
      end else if (exc_ov) begin
         code_sel = 5'd12;
      end else if (exc_syscall) begin
         code_sel = 5'd8;
      end else if (exc_break) begin
         code_sel = 5'd9;
      end else if (exc_adel) begin
         code_sel  = 5'd4;
         bv_en_sel = 1'b1;
         bv_sel    = commit_dvaddr;
      end else if (exc_ades) begin
         code_sel  = 5'd5;
         bv_en_sel = 1'b1;
         bv_sel    = commit_dvaddr;
      end
   end

   always_comb begin
      state_n           = state;
      cnt_n             = cnt;
      last_code_n       = last_code;
      last_bd_n         = last_bd;
      exp_en_n          = 1'b0;
      exp_badvaddr_en_n = 1'b0;
      exp_bd_n          = 1'b0;
      exl_clean_n       = 1'b0;
      exp_badvaddr_n    = 32'd0;
      exp_epc_n         = 32'd0;
      exp_code_n        = 5'd0;
      flush_n           = 1'b0;
      redirect_valid_n  = 1'b0;
      redirect_pc_n     = 32'd0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_n          = REDIRECT;
               exp_en_n         = 1'b1;
               flush_n          = 1'b1;
               redirect_valid_n = 1'b1;
               if (int_req || sync_exc) begin
                  exp_code_n        = code_sel;
                  exp_bd_n          = commit_bd;
                  exp_epc_n         = epc_calc;
                  exp_badvaddr_en_n = bv_en_sel;
                  exp_badvaddr_n    = bv_sel;
                  redirect_pc_n     = VECTOR;
                  last_code_n       = code_sel;
                  last_bd_n         = commit_bd;
               end else begin
                  // ERET reports the cause of the exception it returns from.
                  exl_clean_n   = 1'b1;
                  exp_code_n    = last_code;
                  exp_bd_n      = last_bd;
                  exp_epc_n     = epc_address;
                  redirect_pc_n = epc_address;
               end
            end
         end
         REDIRECT: begin
            state_n = DRAIN;
            cnt_n   = DRAIN_LOAD;
            flush_n = 1'b1;
         end
         DRAIN: begin
            if (cnt <= 4'd1) begin
               state_n = IDLE;
               cnt_n   = 4'd0;
            end else begin
               cnt_n   = cnt - 4'd1;
               flush_n = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= 4'd0;
         last_code       <= 5'd0;
         last_bd         <= 1'b0;
         sync1           <= 6'd0;
         hw_int_sync     <= 6'd0;
         exp_en          <= 1'b0;
         exp_badvaddr_en <= 1'b0;
         exp_bd          <= 1'b0;
         exl_clean       <= 1'b0;
         exp_badvaddr    <= 32'd0;
         exp_epc         <= 32'd0;
         exp_code        <= 5'd0;
         flush           <= 1'b0;
         redirect_valid  <= 1'b0;
         redirect_pc     <= 32'd0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         last_code       <= last_code_n;
         last_bd         <= last_bd_n;
         sync1           <= hw_int;
         hw_int_sync     <= sync1;
         exp_en          <= exp_en_n;
         exp_badvaddr_en <= exp_badvaddr_en_n;
         exp_bd          <= exp_bd_n;
         exl_clean       <= exl_clean_n;
         exp_badvaddr    <= exp_badvaddr_n;
         exp_epc         <= exp_epc_n;
         exp_code        <= exp_code_n;
         flush           <= flush_n;
         redirect_valid  <= redirect_valid_n;
         redirect_pc     <= redirect_pc_n;
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a cycle-level reference model.
module tb_exception_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;
   localparam int D = 2;

   logic        clk, rst;
   logic        commit_valid, commit_bd;
   logic [31:0] commit_pc, commit_dvaddr, epc_address;
   logic        exc_if_adel, exc_ri, exc_ov, exc_syscall, exc_break;
   logic        exc_adel, exc_ades, exc_eret;
   logic [5:0]  hw_int, hw_int_sync;
   logic        allow_interrupt;
   logic [7:0]  interrupt_flag;
   logic        exp_en, exp_badvaddr_en, exp_bd, exl_clean;
   logic [31:0] exp_badvaddr, exp_epc, redirect_pc;
   logic [4:0]  exp_code;
   logic        flush, redirect_valid;
   logic [1:0]  dbg_state;

   int pass_cnt = 0;
   int total    = 0;

   exception_ctrl #(.VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_bd(commit_bd),
      .exc_if_adel(exc_if_adel), .exc_ri(exc_ri), .exc_ov(exc_ov),
      .exc_syscall(exc_syscall), .exc_break(exc_break), .exc_adel(exc_adel),
      .exc_ades(exc_ades), .exc_eret(exc_eret),
      .commit_dvaddr(commit_dvaddr), .hw_int(hw_int), .epc_address(epc_address),
      .allow_interrupt(allow_interrupt), .interrupt_flag(interrupt_flag),
      .hw_int_sync(hw_int_sync), .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en),
      .exp_bd(exp_bd), .exl_clean(exl_clean), .exp_badvaddr(exp_badvaddr),
      .exp_epc(exp_epc), .exp_code(exp_code), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // flags order: {if_adel, ri, ov, syscall, break, adel, ades, eret}
   typedef struct {
      logic [31:0] pc;
      logic        bd;
      logic [7:0]  flags;
      logic [31:0] dv;
      logic [31:0] epca;
      logic        allow;
      logic [7:0]  iflag;
      logic        e_bven;
      logic [31:0] e_badv;
      logic [31:0] e_epc;
      logic [4:0]  e_code;
      logic        e_bd;
      logic        e_exl;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(logic [31:0] pc, logic bd, logic [7:0] flags,
                               logic [31:0] dv, logic [31:0] epca, logic allow,
                               logic [7:0] iflag, logic e_bven, logic [31:0] e_badv,
                               logic [31:0] e_epc, logic [4:0] e_code, logic e_bd,
                               logic e_exl, logic [31:0] e_rpc);
      vec_t v;
      v.pc = pc; v.bd = bd; v.flags = flags; v.dv = dv; v.epca = epca;
      v.allow = allow; v.iflag = iflag; v.e_bven = e_bven; v.e_badv = e_badv;
      v.e_epc = e_epc; v.e_code = e_code; v.e_bd = e_bd; v.e_exl = e_exl;
      v.e_rpc = e_rpc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(logic [7:0] f);
      {exc_if_adel, exc_ri, exc_ov, exc_syscall, exc_break,
       exc_adel, exc_ades, exc_eret} = f;
   endtask

   task automatic idle_inputs();
      commit_valid = 1'b0; commit_bd = 1'b0; commit_pc = 32'd0;
      commit_dvaddr = 32'd0; epc_address = 32'd0;
      allow_interrupt = 1'b0; interrupt_flag = 8'd0;
      set_flags(8'd0);
   endtask

   task automatic check_quiet(string tag);
      chk({tag, ".exp_en"}, 32'(exp_en), 32'd0);
      chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
      chk({tag, ".flush"}, 32'(flush), 32'd0);
      chk({tag, ".exl_clean"}, 32'(exl_clean), 32'd0);
      chk({tag, ".badvaddr_en"}, 32'(exp_badvaddr_en), 32'd0);
   endtask

   task automatic check_drain(string tag);
      for (int k = 0; k < D; k++) begin
         tick();
         chk({tag, ".drain_flush"}, 32'(flush), 32'd1);
         chk({tag, ".drain_exp_en"}, 32'(exp_en), 32'd0);
         chk({tag, ".drain_rv"}, 32'(redirect_valid), 32'd0);
      end
      tick();
      chk({tag, ".idle_flush"}, 32'(flush), 32'd0);
   endtask

   task automatic apply_vec(int i);
      string t;
      t = $sformatf("vec%0d", i);
      commit_valid = 1'b1; commit_pc = vecs[i].pc; commit_bd = vecs[i].bd;
      commit_dvaddr = vecs[i].dv; epc_address = vecs[i].epca;
      allow_interrupt = vecs[i].allow; interrupt_flag = vecs[i].iflag;
      set_flags(vecs[i].flags);
      tick();
      idle_inputs();
      chk({t, ".exp_en"}, 32'(exp_en), 32'd1);
      chk({t, ".flush"}, 32'(flush), 32'd1);
      chk({t, ".redirect_valid"}, 32'(redirect_valid), 32'd1);
      chk({t, ".exl_clean"}, 32'(exl_clean), 32'(vecs[i].e_exl));
      chk({t, ".exp_code"}, 32'(exp_code), 32'(vecs[i].e_code));
      chk({t, ".exp_bd"}, 32'(exp_bd), 32'(vecs[i].e_bd));
      chk({t, ".exp_epc"}, exp_epc, vecs[i].e_epc);
      chk({t, ".redirect_pc"}, redirect_pc, vecs[i].e_rpc);
      chk({t, ".badvaddr_en"}, 32'(exp_badvaddr_en), 32'(vecs[i].e_bven));
      if (vecs[i].e_bven) chk({t, ".badvaddr"}, exp_badvaddr, vecs[i].e_badv);
      check_drain(t);
   endtask

   // reference model state
   int          m_rem;
   logic [4:0]  m_last_code;
   logic        m_last_bd;
   logic [5:0]  m_s1, m_s2;

   initial begin
      rst = 1'b1;
      hw_int = 6'd0;
      idle_inputs();

      // reset state
      tick();
      check_quiet("reset");
      chk("reset.redirect_pc", redirect_pc, 32'd0);
      chk("reset.exp_epc", exp_epc, 32'd0);
      chk("reset.exp_code", 32'(exp_code), 32'd0);
      chk("reset.hw_int_sync", 32'(hw_int_sync), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check_quiet("idle");

      //          pc            bd flags  dvaddr        epc_addr      al iflag bven badv        epc           code bd exl rpc
      vecs[0] = mk(32'h8000_0010, 0, 8'h20, 32'h0,        32'h0,        0, 8'h00, 0, 32'h0,        32'h8000_0010, 12, 0, 0, VEC);
      vecs[1] = mk(32'h8000_0024, 1, 8'h04, 32'h1234_5671, 32'h0,       0, 8'h00, 1, 32'h1234_5671, 32'h8000_0020, 4,  1, 0, VEC);
      vecs[2] = mk(32'h8000_0100, 0, 8'h01, 32'h0,        32'h8000_0020, 0, 8'h00, 0, 32'h0,        32'h8000_0020, 4,  1, 1, 32'h8000_0020);
      vecs[3] = mk(32'h8000_0040, 0, 8'h10, 32'h0,        32'h0,        1, 8'h04, 0, 32'h0,        32'h8000_0040, 0,  0, 0, VEC);
      vecs[4] = mk(32'h8000_0003, 0, 8'h80, 32'h5555_0000, 32'h0,       0, 8'h00, 1, 32'h8000_0003, 32'h8000_0003, 4,  0, 0, VEC);
      vecs[5] = mk(32'h8000_1000, 1, 8'h40, 32'h0,        32'h0,        0, 8'h00, 0, 32'h0,        32'h8000_0FFC, 10, 1, 0, VEC);
      vecs[6] = mk(32'h0000_0000, 1, 8'h08, 32'h0,        32'h0,        0, 8'h00, 0, 32'h0,        32'hFFFF_FFFC, 9,  1, 0, VEC);
      vecs[7] = mk(32'h8000_2000, 0, 8'h02, 32'hDEAD_BEEF, 32'h0,       0, 8'h00, 1, 32'hDEAD_BEEF, 32'h8000_2000, 5,  0, 0, VEC);
      vecs[8] = mk(32'h8000_3000, 0, 8'h41, 32'h0,        32'h7777_0000, 0, 8'h00, 0, 32'h0,       32'h8000_3000, 10, 0, 0, VEC);
      vecs[9] = mk(32'h8000_4000, 1, 8'h01, 32'h0,        32'h9000_0000, 0, 8'h00, 0, 32'h0,       32'h9000_0000, 10, 0, 1, 32'h9000_0000);
      for (int i = 0; i < 10; i++) apply_vec(i);

      // interrupt masked by allow_interrupt=0: no event
      commit_valid = 1'b1; commit_pc = 32'h8000_5000;
      allow_interrupt = 1'b0; interrupt_flag = 8'hFF;
      tick();
      idle_inputs();
      check_quiet("masked_int");

      // pending interrupt waits for a valid commit
      allow_interrupt = 1'b1; interrupt_flag = 8'h80;
      tick(); check_quiet("int_novalid0");
      tick(); check_quiet("int_novalid1");
      commit_valid = 1'b1; commit_pc = 32'h8000_6000;
      tick();
      idle_inputs();
      chk("int_late.exp_en", 32'(exp_en), 32'd1);
      chk("int_late.exp_code", 32'(exp_code), 32'd0);
      chk("int_late.exp_epc", exp_epc, 32'h8000_6000);
      chk("int_late.badvaddr_en", 32'(exp_badvaddr_en), 32'd0);
      check_drain("int_late");

      // second event during REDIRECT/DRAIN is dropped
      commit_valid = 1'b1; commit_pc = 32'h8000_7000; set_flags(8'h20);
      tick();
      chk("drop.first_en", 32'(exp_en), 32'd1);
      set_flags(8'h40); commit_pc = 32'h8000_7004;
      allow_interrupt = 1'b1; interrupt_flag = 8'h01;
      for (int k = 0; k < D; k++) begin
         tick();
         chk("drop.exp_en", 32'(exp_en), 32'd0);
         chk("drop.flush", 32'(flush), 32'd1);
      end
      tick();
      idle_inputs();
      check_quiet("drop.back_idle");
      tick();
      check_quiet("drop.after");

      // reset mid-DRAIN, then ERET sees cleared last-code/last-bd
      commit_valid = 1'b1; commit_pc = 32'h8000_8004; commit_bd = 1'b1;
      commit_dvaddr = 32'h0000_0011; set_flags(8'h04);
      tick();
      idle_inputs();
      tick();
      chk("rstmid.in_drain_flush", 32'(flush), 32'd1);
      #3 rst = 1'b1;
      #1;
      check_quiet("rstmid");
      chk("rstmid.redirect_pc", redirect_pc, 32'd0);
      chk("rstmid.exp_code", 32'(exp_code), 32'd0);
      commit_valid = 1'b1; set_flags(8'h01); epc_address = 32'h8000_9000;
      tick();
      check_quiet("rstmid.held");
      @(negedge clk);
      rst = 1'b0;
      tick();
      idle_inputs();
      chk("rstmid.eret_en", 32'(exp_en), 32'd1);
      chk("rstmid.eret_exl", 32'(exl_clean), 32'd1);
      chk("rstmid.eret_code", 32'(exp_code), 32'd0);
      chk("rstmid.eret_bd", 32'(exp_bd), 32'd0);
      chk("rstmid.eret_rpc", redirect_pc, 32'h8000_9000);
      check_drain("rstmid");

      // hw_int synchronizer latency
      hw_int = 6'b001000;
      tick();
      chk("sync.one_edge", 32'(hw_int_sync[3]), 32'd0);
      tick();
      chk("sync.two_edges", 32'(hw_int_sync[3]), 32'd1);
      hw_int = 6'd0;

      // randomized run against the reference model
      rst = 1'b1;
      tick();
      @(negedge clk);
      rst = 1'b0;
      m_rem = 0; m_last_code = 5'd0; m_last_bd = 1'b0; m_s1 = 6'd0; m_s2 = 6'd0;
      for (int n = 0; n < 600; n++) begin
         logic [7:0]  f;
         logic        e_en, e_flush, e_exl, e_bven, e_bd, intr, syn;
         logic [31:0] e_badv, e_epc, e_rpc;
         logic [4:0]  e_code;
         logic [5:0]  hw_now;
         commit_valid    = ($urandom_range(0, 3) != 0);
         commit_pc       = $urandom;
         commit_bd       = 1'($urandom_range(0, 1));
         commit_dvaddr   = $urandom;
         epc_address     = $urandom;
         allow_interrupt = 1'($urandom_range(0, 1));
         interrupt_flag  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
         hw_int          = 6'($urandom);
         hw_now          = hw_int;
         f = 8'd0;
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 11) == 0) f[b] = 1'b1;
         set_flags(f);

         e_en = 0; e_flush = 0; e_exl = 0; e_bven = 0; e_bd = 0;
         e_badv = 0; e_epc = 0; e_rpc = 0; e_code = 0;
         intr = allow_interrupt && (interrupt_flag != 0);
         syn  = (f[7:1] != 0);
         if (m_rem > 0) begin
            m_rem   = m_rem - 1;
            e_flush = (m_rem > 0);
         end else if (commit_valid && (intr || syn || f[0])) begin
            e_en = 1; e_flush = 1; m_rem = D + 1;
            if (intr || syn) begin
               e_rpc = VEC;
               e_bd  = commit_bd;
               e_epc = commit_bd ? commit_pc - 32'd4 : commit_pc;
               if (intr) e_code = 0;
               else if (f[7]) begin e_code = 4; e_bven = 1; e_badv = commit_pc; end
               else if (f[6]) e_code = 10;
               else if (f[5]) e_code = 12;
               else if (f[4]) e_code = 8;
               else if (f[3]) e_code = 9;
               else if (f[2]) begin e_code = 4; e_bven = 1; e_badv = commit_dvaddr; end
               else begin e_code = 5; e_bven = 1; e_badv = commit_dvaddr; end
               m_last_code = e_code;
               m_last_bd   = e_bd;
            end else begin
               e_exl  = 1;
               e_code = m_last_code;
               e_bd   = m_last_bd;
               e_epc  = epc_address;
               e_rpc  = epc_address;
            end
         end
         m_s2 = m_s1;
         m_s1 = hw_now;

         tick();
         chk("rnd.exp_en", 32'(exp_en), 32'(e_en));
         chk("rnd.flush", 32'(flush), 32'(e_flush));
         chk("rnd.redirect_valid", 32'(redirect_valid), 32'(e_en));
         chk("rnd.exl_clean", 32'(exl_clean), 32'(e_exl));
         chk("rnd.badvaddr_en", 32'(exp_badvaddr_en), 32'(e_bven));
         chk("rnd.hw_int_sync", 32'(hw_int_sync), 32'(m_s2));
         if (e_en) begin
            chk("rnd.exp_code", 32'(exp_code), 32'(e_code));
            chk("rnd.exp_bd", 32'(exp_bd), 32'(e_bd));
            chk("rnd.exp_epc", exp_epc, e_epc);
            chk("rnd.redirect_pc", redirect_pc, e_rpc);
         end
         if (e_bven) chk("rnd.badvaddr", exp_badvaddr, e_badv);
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
